// File: rtl/vec_mm_control_if.sv
// -----------------------------------------------------------------------------
// vec_mm_control_if
// Bundles the controller-to-datapath signals of the vector memory-to-memory
// engine.
//   master : the controller. It receives op/vlen/mem_ready and drives all
//            enables, selects and status flags.
//   slave  : the datapath/memory side, which sees the same signals from the
//            other direction.
// Signals: op, vlen, mem_ready (controller inputs); mem_read, mem_write,
//   addr_sel, ir_write, a_write, b_write, pc_write, pc_write_cond, pc_src,
//   alu_op, elem_idx, busy, done, illegal (controller outputs).
// Optional: retired[31:0], present only when VCTRL_PERF_EN is defined.
// -----------------------------------------------------------------------------
interface vec_mm_control_if #(
    parameter int OP_W  = 8,
    parameter int IDX_W = 4
);
    logic [OP_W-1:0]  op;
    logic [IDX_W:0]   vlen;
    logic             mem_ready;
    logic             mem_read;
    logic             mem_write;
    logic [1:0]       addr_sel;
    logic             ir_write;
    logic             a_write;
    logic             b_write;
    logic             pc_write;
    logic             pc_write_cond;
    logic [1:0]       pc_src;
    logic [3:0]       alu_op;
    logic [IDX_W-1:0] elem_idx;
    logic             busy;
    logic             done;
    logic             illegal;
`ifdef VCTRL_PERF_EN
    logic [31:0]      retired;
`endif

    modport master (
        input  op, vlen, mem_ready,
        output mem_read, mem_write, addr_sel, ir_write, a_write, b_write,
               pc_write, pc_write_cond, pc_src, alu_op, elem_idx,
               busy, done, illegal
`ifdef VCTRL_PERF_EN
        , output retired
`endif
    );

    modport slave (
        output op, vlen, mem_ready,
        input  mem_read, mem_write, addr_sel, ir_write, a_write, b_write,
               pc_write, pc_write_cond, pc_src, alu_op, elem_idx,
               busy, done, illegal
`ifdef VCTRL_PERF_EN
        , input retired
`endif
    );
endinterface

// File: rtl/vec_mm_control.sv
// -----------------------------------------------------------------------------
// vec_mm_control
// Multicycle control FSM for the memory-to-memory vector datapath. Fetches
// and decodes each instruction, then runs a per-element loop of read A,
// read B, ALU and write-back for vector arithmetic opcodes (0..3). It also
// handles branches (4..15), register jumps (24), halt (25) and traps on any
// other opcode. Memory requests complete on mem_ready, so memory latency can
// vary from cycle to cycle.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; all outputs are forced to 0 while high
//   bus   : vec_mm_control_if.master (op/vlen/mem_ready in, controls out)
// Optional feature: define VCTRL_PERF_EN to add bus.retired, a saturating
//   count of instructions that returned to FETCH.
// -----------------------------------------------------------------------------
module vec_mm_control #(
    parameter int OP_W     = 8,
    parameter int VLEN_MAX = 16,
    parameter int IDX_W    = 4
) (
    input  logic                clk,
    input  logic                reset,
    vec_mm_control_if.master    bus
);

    localparam logic [IDX_W:0] L_VLEN_MAX = (IDX_W+1)'(VLEN_MAX);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_RD_A, S_RD_B, S_EX,
        S_WB, S_BRANCH, S_JR, S_HALT, S_TRAP
    } state_t;

    state_t           r_state, w_next;
    logic [IDX_W-1:0] r_idx, w_idx_next;
    logic [IDX_W:0]   r_vlen_q, w_vlen_q_next;
    logic [IDX_W:0]   w_vlen_clip;
    logic             w_last;

    logic             w_mem_read, w_mem_write, w_ir_write, w_a_write, w_b_write;
    logic             w_pc_write, w_pc_write_cond, w_busy, w_done, w_illegal;
    logic [1:0]       w_addr_sel, w_pc_src;
    logic [3:0]       w_alu_op;

    assign w_vlen_clip = (bus.vlen > L_VLEN_MAX) ? L_VLEN_MAX : bus.vlen;
    // Only meaningful inside the element loop, where r_vlen_q >= 1.
    assign w_last      = ({1'b0, r_idx} == (r_vlen_q - 1'b1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_FETCH;
            r_idx    <= '0;
            r_vlen_q <= '0;
        end else begin
            r_state  <= w_next;
            r_idx    <= w_idx_next;
            r_vlen_q <= w_vlen_q_next;
        end
    end

    always_comb begin
        w_next          = r_state;
        w_idx_next      = r_idx;
        w_vlen_q_next   = r_vlen_q;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_addr_sel      = 2'b00;
        w_ir_write      = 1'b0;
        w_a_write       = 1'b0;
        w_b_write       = 1'b0;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_pc_src        = 2'b00;
        w_alu_op        = 4'b0000;
        w_busy          = 1'b1;
        w_done          = 1'b0;
        w_illegal       = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_mem_read = 1'b1;
                if (bus.mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                w_vlen_q_next = w_vlen_clip;
                w_idx_next    = '0;
                if (bus.op <= OP_W'(3))
                    // A zero-length vector op retires without touching memory.
                    w_next = (w_vlen_clip == '0) ? S_FETCH : S_RD_A;
                else if (bus.op <= OP_W'(15))
                    w_next = S_BRANCH;
                else if (bus.op == OP_W'(24))
                    w_next = S_JR;
                else if (bus.op == OP_W'(25))
                    w_next = S_HALT;
                else
                    w_next = S_TRAP;
            end
            S_RD_A: begin
                w_mem_read = 1'b1;
                w_addr_sel = 2'b01;
                if (bus.mem_ready) begin
                    w_a_write = 1'b1;
                    w_next    = S_RD_B;
                end
            end
            S_RD_B: begin
                w_mem_read = 1'b1;
                w_addr_sel = 2'b10;
                if (bus.mem_ready) begin
                    w_b_write = 1'b1;
                    w_next    = S_EX;
                end
            end
            S_EX: begin
                w_alu_op = bus.op[3:0];
                w_next   = S_WB;
            end
            S_WB: begin
                w_mem_write = 1'b1;
                w_addr_sel  = 2'b11;
                // ALU result must stay stable until memory accepts the write.
                w_alu_op    = bus.op[3:0];
                if (bus.mem_ready) begin
                    if (w_last) begin
                        w_next     = S_FETCH;
                        w_idx_next = '0;
                    end else begin
                        w_next     = S_RD_A;
                        w_idx_next = r_idx + 1'b1;
                    end
                end
            end
            S_BRANCH: begin
                w_pc_write_cond = 1'b1;
                w_pc_src        = 2'b01;
                w_alu_op        = 4'b0100;
                w_next          = S_FETCH;
            end
            S_JR: begin
                w_pc_write = 1'b1;
                w_pc_src   = 2'b11;
                w_next     = S_FETCH;
            end
            S_HALT: begin
                w_busy = 1'b0;
                w_done = 1'b1;
            end
            S_TRAP: begin
                w_busy    = 1'b0;
                w_done    = 1'b1;
                w_illegal = 1'b1;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase

        // The state register idles in FETCH during reset; mask its decode so
        // nothing is requested until reset is released.
        if (reset) begin
            w_mem_read      = 1'b0;
            w_mem_write     = 1'b0;
            w_addr_sel      = 2'b00;
            w_ir_write      = 1'b0;
            w_a_write       = 1'b0;
            w_b_write       = 1'b0;
            w_pc_write      = 1'b0;
            w_pc_write_cond = 1'b0;
            w_pc_src        = 2'b00;
            w_alu_op        = 4'b0000;
            w_busy          = 1'b0;
            w_done          = 1'b0;
            w_illegal       = 1'b0;
        end
    end

    assign bus.mem_read      = w_mem_read;
    assign bus.mem_write     = w_mem_write;
    assign bus.addr_sel      = w_addr_sel;
    assign bus.ir_write      = w_ir_write;
    assign bus.a_write       = w_a_write;
    assign bus.b_write       = w_b_write;
    assign bus.pc_write      = w_pc_write;
    assign bus.pc_write_cond = w_pc_write_cond;
    assign bus.pc_src        = w_pc_src;
    assign bus.alu_op        = w_alu_op;
    assign bus.elem_idx      = r_idx;
    assign bus.busy          = w_busy;
    assign bus.done          = w_done;
    assign bus.illegal       = w_illegal;

`ifdef VCTRL_PERF_EN
    logic [31:0] r_retired;
    logic        w_retire;

    // An instruction retires when control returns to FETCH from any
    // instruction-completing state.
    assign w_retire = (w_next == S_FETCH) &&
                      ((r_state == S_DECODE) || (r_state == S_WB) ||
                       (r_state == S_BRANCH) || (r_state == S_JR));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_retired <= '0;
        else if (w_retire && (r_retired != 32'hFFFF_FFFF))
            r_retired <= r_retired + 32'd1;
    end

    assign bus.retired = r_retired;
`endif

endmodule

// File: tb/tb_vec_mm_control.sv
module tb_vec_mm_control;
    localparam int OP_W     = 8;
    localparam int IDX_W    = 4;
    localparam int VLEN_MAX = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vec_mm_control_if #(.OP_W(OP_W), .IDX_W(IDX_W)) bus();

    vec_mm_control #(.OP_W(OP_W), .VLEN_MAX(VLEN_MAX), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus phases an instruction is expected to walk through.
    typedef enum int {K_FETCH, K_DECODE, K_RDA, K_RDB, K_EX, K_WB,
                      K_BR, K_JR, K_HALT, K_TRAP} kind_t;
    typedef struct {kind_t kind; int idx;} phase_t;

    longint ret_exp = 0;
    int     wr_cycles = 0;
    int     data_reads = 0;

    function automatic logic [22:0] observed();
        return {bus.mem_read, bus.mem_write, bus.addr_sel, bus.ir_write,
                bus.a_write, bus.b_write, bus.pc_write, bus.pc_write_cond,
                bus.pc_src, bus.alu_op, bus.busy, bus.done, bus.illegal,
                bus.elem_idx};
    endfunction

    function automatic logic [22:0] expected(kind_t k, int idx, logic rdy, logic [7:0] opv);
        logic       mr = 0, mw = 0, irw = 0, aw = 0, bw = 0, pw = 0, pwc = 0;
        logic       bsy = 1, dn = 0, ill = 0;
        logic [1:0] as = 0, ps = 0;
        logic [3:0] alu = 0, ei = 0;
        case (k)
            K_FETCH:  begin mr = 1; irw = rdy; pw = rdy; end
            K_DECODE: ;
            K_RDA:    begin mr = 1; as = 2'b01; aw = rdy; ei = idx[3:0]; end
            K_RDB:    begin mr = 1; as = 2'b10; bw = rdy; ei = idx[3:0]; end
            K_EX:     begin alu = opv[3:0]; ei = idx[3:0]; end
            K_WB:     begin mw = 1; as = 2'b11; alu = opv[3:0]; ei = idx[3:0]; end
            K_BR:     begin pwc = 1; ps = 2'b01; alu = 4'b0100; end
            K_JR:     begin pw = 1; ps = 2'b11; end
            K_HALT:   begin bsy = 0; dn = 1; end
            K_TRAP:   begin bsy = 0; dn = 1; ill = 1; end
            default:  ;
        endcase
        return {mr, mw, as, irw, aw, bw, pw, pwc, ps, alu, bsy, dn, ill, ei};
    endfunction

    // One clock cycle: drive mem_ready, compare, advance to just after the edge.
    task automatic cycle(input kind_t k, input int idx, input logic rdy, input logic [7:0] opv);
        bus.mem_ready = rdy;
        #1;
        check($sformatf("%s[%0d] op=%0d", k.name(), idx, opv), observed(), expected(k, idx, rdy, opv));
`ifdef VCTRL_PERF_EN
        check("retired", bus.retired, ret_exp);
`endif
        if (bus.mem_write) wr_cycles++;
        if (bus.mem_read && bus.addr_sel != 2'b00) data_reads++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) begin
            bus.mem_ready = 1'($urandom);
            #1;
            check("reset_outputs", observed(), 23'd0);
`ifdef VCTRL_PERF_EN
            check("reset_retired", bus.retired, 0);
`endif
            @(posedge clk);
            #1;
        end
        reset   = 1'b0;
        ret_exp = 0;
    endtask

    // mode 0: memory always ready; 1: random wait states; 2: 2 waits in RD_A.
    task automatic run_instr(input logic [7:0] opv, input int vl, input int mode, input int abort_idx);
        phase_t q[$];
        int     n, w;
        q.push_back('{K_FETCH, 0});
        q.push_back('{K_DECODE, 0});
        if (opv <= 3) begin
            n = (vl > VLEN_MAX) ? VLEN_MAX : vl;
            for (int i = 0; i < n; i++) begin
                q.push_back('{K_RDA, i});
                q.push_back('{K_RDB, i});
                q.push_back('{K_EX, i});
                q.push_back('{K_WB, i});
            end
        end else if (opv <= 15) q.push_back('{K_BR, 0});
        else if (opv == 24)     q.push_back('{K_JR, 0});
        else if (opv == 25)     q.push_back('{K_HALT, 0});
        else                    q.push_back('{K_TRAP, 0});

        bus.op   = opv;
        bus.vlen = vl[IDX_W:0];
        foreach (q[p]) begin
            // vlen is sampled only in DECODE; scramble it afterwards.
            if (p >= 2) bus.vlen = 5'($urandom);
            case (q[p].kind)
                K_FETCH, K_RDA, K_RDB, K_WB: begin
                    if (q[p].kind == K_WB && q[p].idx == abort_idx) begin
                        cycle(K_WB, q[p].idx, 1'b0, opv);
                        do_reset();
                        return;
                    end
                    w = (mode == 0) ? 0 :
                        (mode == 1) ? int'($urandom_range(0, 3)) :
                        ((q[p].kind == K_RDA) ? 2 : 0);
                    for (int c = 0; c <= w; c++)
                        cycle(q[p].kind, q[p].idx, (c == w), opv);
                end
                K_HALT, K_TRAP: begin
                    repeat (5) cycle(q[p].kind, 0, 1'($urandom), opv);
                    do_reset();
                    return;
                end
                default: cycle(q[p].kind, q[p].idx, 1'($urandom), opv);
            endcase
        end
        if (ret_exp < 64'hFFFF_FFFF) ret_exp++;
    endtask

    initial begin
        int r;
        logic [7:0] rop;
        reset         = 1'b1;
        bus.op        = '0;
        bus.vlen      = '0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        wr_cycles = 0;
        run_instr(8'd0, 3, 0, -1);
        check("op0_vlen3_write_cycles", wr_cycles, 3);

        run_instr(8'd1, 2, 2, -1);

        data_reads = 0;
        run_instr(8'd2, 0, 1, -1);
        check("vlen0_data_reads", data_reads, 0);

        run_instr(8'd4, 5, 1, -1);
        run_instr(8'd24, 1, 0, -1);
        run_instr(8'd3, 31, 0, -1);
        run_instr(8'd0, 16, 1, -1);
        run_instr(8'd25, 2, 1, -1);
        run_instr(8'd40, 2, 1, -1);

        wr_cycles = 0;
        run_instr(8'd0, 3, 0, 1);
        check("abort_write_cycles", wr_cycles, 2);
        run_instr(8'd15, 0, 0, -1);

        for (int t = 0; t < 100; t++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3, 4, 5: rop = 8'($urandom_range(0, 3));
                6:                rop = 8'($urandom_range(4, 15));
                7:                rop = 8'd24;
                8:                rop = ($urandom_range(0, 1) == 1) ? 8'd25 : 8'($urandom_range(26, 255));
                default:          rop = 8'($urandom_range(0, 3));
            endcase
            run_instr(rop, $urandom_range(0, 31), $urandom_range(0, 2),
                      (r == 9) ? int'($urandom_range(0, 3)) : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
